// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: main pipeline vs. a 2-deep MDU result FIFO,
// with starvation forcing and a pending-write scoreboard for MDU destinations.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_dest,
    input  logic [31:0] pipe_result,
    output logic        pipe_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dest,
    input  logic [31:0] mdu_result,
    output logic        mdu_ready,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_dest,
    output logic        issue_ok,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        writeBackEn,
    output logic [4:0]  Dest_wb,
    output logic [31:0] Result_WB
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [4:0]    r_fifo_dest [0:1];
    logic [31:0]   r_fifo_data [0:1];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_count;
    logic [CW-1:0] r_starve;
    logic [31:0]   r_pending;
    logic          r_wb_en;
    logic [4:0]    r_dest;
    logic [31:0]   r_result;

    logic          w_empty;
    logic          w_full;
    logic          w_force;
    logic          w_push;
    logic          w_grant_pipe;
    logic          w_grant_fifo;
    logic [4:0]    w_head_dest;
    logic [31:0]   w_head_data;
    logic [4:0]    w_wb_dest;
    logic [31:0]   w_wb_data;
    logic [31:0]   w_pending_next;

    assign w_empty      = (r_count == 2'd0);
    assign w_full       = (r_count == 2'd2);
    assign w_force      = (r_starve == LIMIT) && !w_empty;
    assign w_push       = mdu_valid && !w_full;
    assign w_grant_pipe = pipe_valid && !w_force;
    assign w_grant_fifo = !w_grant_pipe && !w_empty;
    assign w_head_dest  = r_fifo_dest[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];

    assign pipe_ready  = !w_force;
    assign mdu_ready   = !w_full;
    assign issue_ok    = !r_pending[mdu_issue_dest];
    assign hazard1     = (src1 != 5'd0) && r_pending[src1];
    assign hazard2     = (src2 != 5'd0) && r_pending[src2];
    assign writeBackEn = r_wb_en;
    assign Dest_wb     = r_dest;
    assign Result_WB   = r_result;

    // Select the granted source's dest/result for the write port.
    always_comb begin
        w_wb_dest = 5'd0;
        w_wb_data = 32'd0;
        if (w_grant_pipe) begin
            w_wb_dest = pipe_dest;
            w_wb_data = pipe_result;
        end else begin
            w_wb_dest = w_head_dest;
            w_wb_data = w_head_data;
        end
    end

    // Scoreboard update: a granted head can never collide with an accepted issue,
    // since issue_ok is low while the head's dest is still pending.
    always_comb begin
        w_pending_next = r_pending;
        if (w_grant_fifo) begin
            w_pending_next = w_pending_next & ~(32'd1 << w_head_dest);
        end else begin
            w_pending_next = w_pending_next;
        end
        if (mdu_issue && issue_ok && (mdu_issue_dest != 5'd0)) begin
            w_pending_next = w_pending_next | (32'd1 << mdu_issue_dest);
        end else begin
            w_pending_next = w_pending_next;
        end
    end

    // MDU result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_dest[i] <= 5'd0;
                r_fifo_data[i] <= 32'd0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_dest[r_wr_ptr] <= mdu_dest;
                r_fifo_data[r_wr_ptr] <= mdu_result;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_grant_fifo) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_grant_fifo})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter for the FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_grant_fifo) begin
            r_starve <= '0;
        end else begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Pending-write vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Registered write port; register 0 writes are swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_en  <= 1'b0;
            r_dest   <= 5'd0;
            r_result <= 32'd0;
        end else if (w_grant_pipe || w_grant_fifo) begin
            r_wb_en  <= (w_wb_dest != 5'd0);
            r_dest   <= w_wb_dest;
            r_result <= w_wb_data;
        end else begin
            r_wb_en  <= 1'b0;
        end
    end

endmodule
